// File: rtl/pf_dispatch_pkg.sv
// Shared types for the packet-filter dispatcher: FSM state encodings and
// the grant-index width helper.
package pf_dispatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DROP
  } snoop_state_t;

  typedef enum logic {
    F_IDLE,
    F_BUSY
  } fwd_state_t;

  // Width of a VM grant index / round-robin pointer, i.e. $clog2(NUM_VMS).
  function automatic int gnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at N.
module rr_pick
  import pf_dispatch_pkg::*;
#(
  parameter int N = 4,
  parameter int W = gnt_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    int c;
    c      = 0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (req[c]) begin
        idx   = W'(c);
        valid = 1'b1;
      end
    end
    onehot = valid ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/pf_dispatch.sv
// Dispatches snooped packets into per-VM filter memories and presents one
// filtered packet at a time to the forwarder, round-robin on both sides.
module pf_dispatch
  import pf_dispatch_pkg::*;
#(
  parameter int NUM_VMS              = 4,
  parameter int SNOOP_FWD_ADDR_WIDTH = 9,
  parameter int PACKET_DATA_WIDTH    = 64,
  parameter int DROP_CNT_WIDTH       = 16,
  parameter bit DROP_WHEN_BUSY       = 1'b1
) (
  input  logic                                      axi_aclk,
  input  logic                                      axi_aresetn,
  // snooper side
  input  logic [SNOOP_FWD_ADDR_WIDTH-1:0]           snooper_wr_addr,
  input  logic [PACKET_DATA_WIDTH-1:0]              snooper_wr_data,
  input  logic                                      snooper_wr_en,
  input  logic                                      snooper_done,
  output logic                                      ready_for_snooper,
  // VM write side
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0]           vm_wr_addr,
  output logic [PACKET_DATA_WIDTH-1:0]              vm_wr_data,
  output logic [NUM_VMS-1:0]                        vm_wr_en,
  output logic [NUM_VMS-1:0]                        vm_snoop_done,
  input  logic [NUM_VMS-1:0]                        vm_ready_for_snooper,
  // forwarder side
  input  logic [SNOOP_FWD_ADDR_WIDTH-1:0]           forwarder_rd_addr,
  input  logic                                      forwarder_rd_en,
  input  logic                                      forwarder_done,
  output logic [PACKET_DATA_WIDTH-1:0]              forwarder_rd_data,
  output logic                                      ready_for_forwarder,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0]           len_to_forwarder,
  // VM read side
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0]           vm_rd_addr,
  output logic [NUM_VMS-1:0]                        vm_rd_en,
  output logic [NUM_VMS-1:0]                        vm_fwd_done,
  input  logic [NUM_VMS*PACKET_DATA_WIDTH-1:0]      vm_rd_data,
  input  logic [NUM_VMS-1:0]                        vm_ready_for_forwarder,
  input  logic [NUM_VMS*SNOOP_FWD_ADDR_WIDTH-1:0]   vm_len_to_forwarder,
  // statistics
  output logic [DROP_CNT_WIDTH-1:0]                 drop_count,
  input  logic                                      drop_count_clr
);

  localparam int GW = gnt_width(NUM_VMS);
  localparam int AW = SNOOP_FWD_ADDR_WIDTH;
  localparam int DW = PACKET_DATA_WIDTH;

  snoop_state_t         s_state, s_next;
  fwd_state_t           f_state, f_next;
  logic [GW-1:0]        sgnt, sgnt_next, sptr, sptr_next;
  logic [GW-1:0]        fgnt, fgnt_next, fptr, fptr_next;
  logic [NUM_VMS-1:0]   fgnt_oh, fgnt_oh_next;
  logic [NUM_VMS-1:0]   s_oh, f_oh;
  logic [GW-1:0]        s_idx, f_idx;
  logic                 s_valid, f_valid;
  logic                 drop_inc;

  // Pointer advance wraps at NUM_VMS, which need not be a power of two.
  function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g);
    return (int'(g) == NUM_VMS - 1) ? '0 : g + 1'b1;
  endfunction

  rr_pick #(.N(NUM_VMS), .W(GW)) u_snoop_pick (
    .req    (vm_ready_for_snooper),
    .ptr    (sptr),
    .onehot (s_oh),
    .idx    (s_idx),
    .valid  (s_valid)
  );

  rr_pick #(.N(NUM_VMS), .W(GW)) u_fwd_pick (
    .req    (vm_ready_for_forwarder),
    .ptr    (fptr),
    .onehot (f_oh),
    .idx    (f_idx),
    .valid  (f_valid)
  );

  // Write and read address/data buses are shared by all VMs.
  assign vm_wr_addr = snooper_wr_addr;
  assign vm_wr_data = snooper_wr_data;
  assign vm_rd_addr = forwarder_rd_addr;

  // Snoop FSM: route beats to the granted VM, or swallow the packet.
  always_comb begin
    s_next            = s_state;
    sgnt_next         = sgnt;
    sptr_next         = sptr;
    vm_wr_en          = '0;
    vm_snoop_done     = '0;
    drop_inc          = 1'b0;
    ready_for_snooper = 1'b0;
    unique case (s_state)
      S_IDLE: begin
        ready_for_snooper = DROP_WHEN_BUSY ? 1'b1 : |vm_ready_for_snooper;
        if (snooper_wr_en) begin
          if (s_valid) begin
            vm_wr_en  = s_oh;
            sgnt_next = s_idx;
            if (snooper_done) begin
              vm_snoop_done = s_oh;
              sptr_next     = next_ptr(s_idx);
            end else begin
              s_next = S_FILL;
            end
          end else if (snooper_done) begin
            drop_inc = 1'b1;
          end else begin
            s_next = S_DROP;
          end
        end
      end
      S_FILL: begin
        if (snooper_wr_en) vm_wr_en = NUM_VMS'(1) << sgnt;
        if (snooper_done) begin
          vm_snoop_done = NUM_VMS'(1) << sgnt;
          sptr_next     = next_ptr(sgnt);
          s_next        = S_IDLE;
        end
      end
      S_DROP: begin
        if (snooper_done) begin
          drop_inc = 1'b1;
          s_next   = S_IDLE;
        end
      end
      default: s_next = S_IDLE;
    endcase
  end

  // Forward FSM: grant one ready VM and mux its packet to the forwarder.
  always_comb begin
    f_next              = f_state;
    fgnt_next           = fgnt;
    fgnt_oh_next        = fgnt_oh;
    fptr_next           = fptr;
    ready_for_forwarder = 1'b0;
    len_to_forwarder    = '0;
    forwarder_rd_data   = '0;
    vm_rd_en            = '0;
    vm_fwd_done         = '0;
    unique case (f_state)
      F_IDLE: begin
        if (f_valid) begin
          fgnt_next    = f_idx;
          fgnt_oh_next = f_oh;
          f_next       = F_BUSY;
        end
      end
      F_BUSY: begin
        ready_for_forwarder = 1'b1;
        len_to_forwarder    = vm_len_to_forwarder[int'(fgnt)*AW +: AW];
        forwarder_rd_data   = vm_rd_data[int'(fgnt)*DW +: DW];
        if (forwarder_rd_en) vm_rd_en = fgnt_oh;
        if (forwarder_done) begin
          vm_fwd_done = fgnt_oh;
          fptr_next   = next_ptr(fgnt);
          f_next      = F_IDLE;
        end
      end
      default: f_next = F_IDLE;
    endcase
  end

  // State, grant and pointer registers for both FSMs.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      s_state <= S_IDLE;
      f_state <= F_IDLE;
      sgnt    <= '0;
      sptr    <= '0;
      fgnt    <= '0;
      fgnt_oh <= '0;
      fptr    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      s_state <= s_next;
      f_state <= f_next;
      sgnt    <= sgnt_next;
      sptr    <= sptr_next;
      fgnt    <= fgnt_next;
      fgnt_oh <= fgnt_oh_next;
      fptr    <= fptr_next;
    end
  end

  // Saturating drop counter; a clear coinciding with a drop leaves 1.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      drop_count <= '0;
    end else if (drop_count_clr) begin
      drop_count <= drop_inc ? DROP_CNT_WIDTH'(1) : '0;
    end else if (drop_inc && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pf_dispatch.sv
// Directed bench for pf_dispatch with a beat/done scoreboard on the VM side.
module tb_pf_dispatch;

  localparam int NV = 4;
  localparam int AW = 9;
  localparam int DW = 64;

  typedef struct {
    int            vm;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  logic               clk, rst_n;
  logic [AW-1:0]      snooper_wr_addr;
  logic [DW-1:0]      snooper_wr_data;
  logic               snooper_wr_en, snooper_done;
  logic               ready_for_snooper, ready_for_snooper2;
  logic [AW-1:0]      vm_wr_addr, vm_wr_addr2;
  logic [DW-1:0]      vm_wr_data, vm_wr_data2;
  logic [NV-1:0]      vm_wr_en, vm_snoop_done, vm_wr_en2, vm_snoop_done2;
  logic [NV-1:0]      vm_ready_for_snooper;
  logic [AW-1:0]      forwarder_rd_addr;
  logic               forwarder_rd_en, forwarder_done;
  logic [DW-1:0]      forwarder_rd_data, forwarder_rd_data2;
  logic               ready_for_forwarder, ready_for_forwarder2;
  logic [AW-1:0]      len_to_forwarder, len_to_forwarder2;
  logic [AW-1:0]      vm_rd_addr, vm_rd_addr2;
  logic [NV-1:0]      vm_rd_en, vm_fwd_done, vm_rd_en2, vm_fwd_done2;
  logic [NV*DW-1:0]   vm_rd_data;
  logic [NV-1:0]      vm_ready_for_forwarder;
  logic [NV*AW-1:0]   vm_len_to_forwarder;
  logic [15:0]        drop_count;
  logic [1:0]         drop_count2;
  logic               drop_count_clr, drop_count_clr2;

  int    checks = 0;
  int    errors = 0;
  beat_t wq[$];
  int    dq[$];

  pf_dispatch #(.NUM_VMS(NV), .DROP_CNT_WIDTH(16), .DROP_WHEN_BUSY(1'b1)) u_dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .snooper_wr_addr(snooper_wr_addr), .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en), .snooper_done(snooper_done),
    .ready_for_snooper(ready_for_snooper),
    .vm_wr_addr(vm_wr_addr), .vm_wr_data(vm_wr_data), .vm_wr_en(vm_wr_en),
    .vm_snoop_done(vm_snoop_done), .vm_ready_for_snooper(vm_ready_for_snooper),
    .forwarder_rd_addr(forwarder_rd_addr), .forwarder_rd_en(forwarder_rd_en),
    .forwarder_done(forwarder_done), .forwarder_rd_data(forwarder_rd_data),
    .ready_for_forwarder(ready_for_forwarder), .len_to_forwarder(len_to_forwarder),
    .vm_rd_addr(vm_rd_addr), .vm_rd_en(vm_rd_en), .vm_fwd_done(vm_fwd_done),
    .vm_rd_data(vm_rd_data), .vm_ready_for_forwarder(vm_ready_for_forwarder),
    .vm_len_to_forwarder(vm_len_to_forwarder),
    .drop_count(drop_count), .drop_count_clr(drop_count_clr)
  );

  // Second instance: 2-bit counter, backpressure mode, no VM ever ready to snoop.
  pf_dispatch #(.NUM_VMS(NV), .DROP_CNT_WIDTH(2), .DROP_WHEN_BUSY(1'b0)) u_dut2 (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .snooper_wr_addr(snooper_wr_addr), .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en), .snooper_done(snooper_done),
    .ready_for_snooper(ready_for_snooper2),
    .vm_wr_addr(vm_wr_addr2), .vm_wr_data(vm_wr_data2), .vm_wr_en(vm_wr_en2),
    .vm_snoop_done(vm_snoop_done2), .vm_ready_for_snooper('0),
    .forwarder_rd_addr(forwarder_rd_addr), .forwarder_rd_en(forwarder_rd_en),
    .forwarder_done(forwarder_done), .forwarder_rd_data(forwarder_rd_data2),
    .ready_for_forwarder(ready_for_forwarder2), .len_to_forwarder(len_to_forwarder2),
    .vm_rd_addr(vm_rd_addr2), .vm_rd_en(vm_rd_en2), .vm_fwd_done(vm_fwd_done2),
    .vm_rd_data(vm_rd_data), .vm_ready_for_forwarder('0),
    .vm_len_to_forwarder(vm_len_to_forwarder),
    .drop_count(drop_count2), .drop_count_clr(drop_count_clr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] vm_data(input int i);
    return {32'hD0D0_0000 + 32'(i), 32'hCAFE_0000 + 32'(i)};
  endfunction

  // Drive one packet; exp_vm < 0 means the bench expects it to be dropped.
  task automatic send_pkt(input int nbeats, input int exp_vm, input bit with_done);
    for (int b = 0; b < nbeats; b++) begin
      @(posedge clk); #1;
      snooper_wr_en   = 1'b1;
      snooper_wr_addr = AW'(b);
      snooper_wr_data = {$urandom, $urandom};
      snooper_done    = with_done && (b == nbeats - 1);
      if (exp_vm >= 0) begin
        wq.push_back('{vm: exp_vm, addr: snooper_wr_addr, data: snooper_wr_data});
        if (snooper_done) dq.push_back(exp_vm);
      end
    end
    @(posedge clk); #1;
    snooper_wr_en = 1'b0;
    snooper_done  = 1'b0;
  endtask

  // Scoreboard: every VM write and snoop-done must match the next expectation.
  always @(negedge clk) begin
    beat_t e;
    int    v;
    if (rst_n) begin
      if (vm_wr_en !== '0) begin
        if (wq.size() == 0) check("unexpected_vm_wr_en", 64'(vm_wr_en), 64'd0);
        else begin
          e = wq.pop_front();
          check("vm_wr_en", 64'(vm_wr_en), 64'(NV'(1) << e.vm));
          check("vm_wr_addr", 64'(vm_wr_addr), 64'(e.addr));
          check("vm_wr_data", vm_wr_data, e.data);
        end
      end
      if (vm_snoop_done !== '0) begin
        if (dq.size() == 0) check("unexpected_snoop_done", 64'(vm_snoop_done), 64'd0);
        else begin
          v = dq.pop_front();
          check("vm_snoop_done", 64'(vm_snoop_done), 64'(NV'(1) << v));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    snooper_wr_addr = '0; snooper_wr_data = '0; snooper_wr_en = 1'b0; snooper_done = 1'b0;
    vm_ready_for_snooper = '0; vm_ready_for_forwarder = '0;
    forwarder_rd_addr = '0; forwarder_rd_en = 1'b0; forwarder_done = 1'b0;
    drop_count_clr = 1'b0; drop_count_clr2 = 1'b0;
    for (int i = 0; i < NV; i++) begin
      vm_rd_data[i*DW +: DW]          = vm_data(i);
      vm_len_to_forwarder[i*AW +: AW] = AW'(10 + i);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_vm_wr_en", 64'(vm_wr_en), 64'd0);
    check("rst_ready_fwd", 64'(ready_for_forwarder), 64'd0);
    check("rst_ready_snoop", 64'(ready_for_snooper), 64'd1);
    rst_n = 1'b1;

    // Three 8-beat packets, all VMs ready -> VMs 0,1,2
    vm_ready_for_snooper = 4'b1111;
    send_pkt(8, 0, 1'b1);
    send_pkt(8, 1, 1'b1);
    send_pkt(8, 2, 1'b1);
    @(negedge clk);
    check("no_drops", 64'(drop_count), 64'd0);

    // sptr=3, only VM 2 ready -> wraps to VM 2; sptr stays 3 -> VM 3 single beat
    vm_ready_for_snooper = 4'b0100;
    send_pkt(4, 2, 1'b1);
    vm_ready_for_snooper = 4'b1111;
    send_pkt(1, 3, 1'b1);

    // Drops with no VM ready
    vm_ready_for_snooper = 4'b0000;
    @(posedge clk); #1;
    drop_count_clr = 1'b1; drop_count_clr2 = 1'b1;
    @(posedge clk); #1;
    drop_count_clr = 1'b0; drop_count_clr2 = 1'b0;
    @(negedge clk);
    check("clr_before_drops", 64'(drop_count), 64'd0);
    check("ready_snoop_dwb1", 64'(ready_for_snooper), 64'd1);
    check("ready_snoop_dwb0", 64'(ready_for_snooper2), 64'd0);
    for (int p = 0; p < 5; p++) send_pkt(3, -1, 1'b1);
    @(negedge clk);
    check("drop_count_5", 64'(drop_count), 64'd5);
    check("drop_count2_sat", 64'(drop_count2), 64'd3);
    send_pkt(2, -1, 1'b1);
    @(negedge clk);
    check("drop_count_6", 64'(drop_count), 64'd6);
    check("drop_count2_6", 64'(drop_count2), 64'd3);

    // Lone snooper_done in S_IDLE is ignored
    @(posedge clk); #1; snooper_done = 1'b1;
    @(posedge clk); #1; snooper_done = 1'b0;
    @(negedge clk);
    check("lone_done_ignored", 64'(drop_count), 64'd6);

    // Clear coinciding with a single-beat drop -> 1, then plain clear -> 0
    @(posedge clk); #1;
    snooper_wr_en = 1'b1; snooper_done = 1'b1; drop_count_clr = 1'b1;
    @(posedge clk); #1;
    snooper_wr_en = 1'b0; snooper_done = 1'b0; drop_count_clr = 1'b0;
    @(negedge clk);
    check("clr_and_inc", 64'(drop_count), 64'd1);
    @(posedge clk); #1; drop_count_clr = 1'b1;
    @(posedge clk); #1; drop_count_clr = 1'b0;
    @(negedge clk);
    check("clr", 64'(drop_count), 64'd0);

    // Forwarder: done in F_IDLE ignored, then VMs 1 and 3 ready
    @(posedge clk); #1; forwarder_done = 1'b1;
    @(negedge clk);
    check("fwd_done_idle", 64'(vm_fwd_done), 64'd0);
    @(posedge clk); #1; forwarder_done = 1'b0;
    vm_ready_for_forwarder = 4'b1010;
    @(negedge clk);
    check("fwd_latency", 64'(ready_for_forwarder), 64'd0);
    @(posedge clk); #1;
    forwarder_rd_en = 1'b1; forwarder_rd_addr = 9'd5;
    @(negedge clk);
    check("fwd_ready_vm1", 64'(ready_for_forwarder), 64'd1);
    check("fwd_len_vm1", 64'(len_to_forwarder), 64'd11);
    check("fwd_data_vm1", forwarder_rd_data, vm_data(1));
    check("fwd_rd_en_vm1", 64'(vm_rd_en), 64'b0010);
    check("fwd_rd_addr", 64'(vm_rd_addr), 64'd5);
    @(posedge clk); #1;
    forwarder_rd_en = 1'b0; forwarder_done = 1'b1; vm_ready_for_forwarder = 4'b1000;
    @(negedge clk);
    check("fwd_done_vm1", 64'(vm_fwd_done), 64'b0010);
    @(posedge clk); #1; forwarder_done = 1'b0;
    @(negedge clk);
    check("fwd_idle_ready", 64'(ready_for_forwarder), 64'd0);
    check("fwd_idle_len", 64'(len_to_forwarder), 64'd0);
    check("fwd_idle_data", forwarder_rd_data, 64'd0);
    @(posedge clk); #1; forwarder_rd_en = 1'b1;
    @(negedge clk);
    check("fwd_len_vm3", 64'(len_to_forwarder), 64'd13);
    check("fwd_data_vm3", forwarder_rd_data, vm_data(3));
    check("fwd_rd_en_vm3", 64'(vm_rd_en), 64'b1000);

    // Reset mid S_FILL (VM 1) and F_BUSY (VM 3)
    vm_ready_for_snooper = 4'b1111;
    send_pkt(2, 0, 1'b1);
    send_pkt(3, 1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rd_en", 64'(vm_rd_en), 64'd0);
    check("rst_mid_ready_fwd", 64'(ready_for_forwarder), 64'd0);
    check("rst_mid_len", 64'(len_to_forwarder), 64'd0);
    check("rst_mid_fwd_done", 64'(vm_fwd_done), 64'd0);
    check("rst_mid_snoop_done", 64'(vm_snoop_done), 64'd0);
    @(posedge clk); #1;
    forwarder_rd_en = 1'b0;
    vm_ready_for_forwarder = 4'b1001;
    rst_n = 1'b1;
    send_pkt(2, 0, 1'b1);
    @(negedge clk);
    check("post_rst_fwd_len_vm0", 64'(len_to_forwarder), 64'd10);
    check("post_rst_drop_count", 64'(drop_count), 64'd0);

    repeat (2) @(negedge clk);
    check("wq_empty", 64'(wq.size()), 64'd0);
    check("dq_empty", 64'(dq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
